// File: rtl/merge_pkg.sv
// Shared helpers for the merge/mux family: index-width derivation, FSM state type
// and a packed-bus slice macro.
`ifndef MERGE_SLICE
`define MERGE_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package merge_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } merge_state_e;

    function automatic int merge_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // A single-input or degenerate merge still needs a 1-bit index port.
    function automatic int merge_index_width(input int n);
        return (merge_clog2(n) < 1) ? 1 : merge_clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: lowest set request at or above ptr, wrapping to 0.
module rr_priority_select
    import merge_pkg::*;
#(
    parameter int INPUTS      = 2,
    parameter int INDEX_WIDTH = merge_index_width(INPUTS)
) (
    input  logic [INPUTS-1:0]      req,
    input  logic [INDEX_WIDTH-1:0] ptr,
    output logic [INPUTS-1:0]      grant,
    output logic [INDEX_WIDTH-1:0] grant_idx,
    output logic                   any
);

    logic [2*INPUTS-1:0] dbl_req;
    int                  sel;
    int                  idx;

    assign dbl_req = {req, req};

    // Lower copy is masked below ptr; the upper copy supplies the wrapped-around channels.
    always_comb begin
        any = 1'b0;
        sel = 0;
        for (int j = 2*INPUTS-1; j >= 0; j--) begin
            if (dbl_req[j] && (j >= int'(ptr))) begin
                any = 1'b1;
                sel = j;
            end
        end
        idx       = (sel >= INPUTS) ? (sel - INPUTS) : sel;
        grant_idx = INDEX_WIDTH'(idx);
        grant     = any ? (INPUTS'(1) << idx) : '0;
    end

endmodule

// File: rtl/merge_rr_arbiter.sv
// Fair N-to-1 valid/ready merge with a one-slot registered output and winner index.
module merge_rr_arbiter
    import merge_pkg::*;
#(
    parameter int INPUTS      = 2,
    parameter int BITWIDTH    = 32,
    parameter int INDEX_WIDTH = merge_index_width(INPUTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INPUTS*BITWIDTH-1:0] ins,
    input  logic [INPUTS-1:0]          ins_valid,
    output logic [INPUTS-1:0]          ins_ready,
    output logic [BITWIDTH-1:0]        outs,
    output logic                       outs_valid,
    input  logic                       outs_ready,
    output logic [INDEX_WIDTH-1:0]     index
);

    merge_state_e           state_q;
    merge_state_e           state_d;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INPUTS-1:0]      grant;
    logic [INDEX_WIDTH-1:0] grant_idx;
    logic                   any_req;
    logic                   can_accept;
    logic                   transfer;

    rr_priority_select #(
        .INPUTS      (INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_select (
        .req       (ins_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    assign outs_valid = (state_q == FULL);
    assign can_accept = !outs_valid || outs_ready;
    assign ins_ready  = can_accept ? grant : '0;
    assign transfer   = can_accept && any_req;

    // A transfer always fills the slot, even when the old token drains in the same cycle.
    always_comb begin
        state_d = state_q;
        if (transfer) begin
            state_d = FULL;
        end else if (outs_valid && outs_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs  <= '0;
            index <= '0;
            ptr   <= '0;
        end else if (transfer) begin
            outs  <= `MERGE_SLICE(ins, grant_idx, BITWIDTH);
            index <= grant_idx;
            ptr   <= (grant_idx == INDEX_WIDTH'(INPUTS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_merge_rr_arbiter.sv
// Self-checking bench for merge_rr_arbiter (3 inputs) against a round-robin reference model.
module tb_merge_rr_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] ins;
    logic [N-1:0]   ins_valid;
    logic [N-1:0]   ins_ready;
    logic [W-1:0]   outs;
    logic           outs_valid;
    logic           outs_ready;
    logic [IW-1:0]  index;
    logic [W-1:0]   dat [N];

    int           m_ptr;
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_idx;
    int           total;
    int           bad;

    assign ins = {dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    merge_rr_arbiter #(
        .INPUTS      (N),
        .BITWIDTH    (W),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .index      (index)
    );

    // Reference: first valid channel visiting ptr, ptr+1, .. modulo N.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (ins_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = pick();
        if (g >= 0 && (!m_full || outs_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int g;
        g = pick();
        if ((!m_full || outs_ready) && g >= 0) begin
            m_full = 1'b1;
            m_data = dat[g];
            m_idx  = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full && outs_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 1'b0;
        m_data = '0;
        m_idx  = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        ins_valid  = v;
        outs_ready = r;
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) dat[i] = $urandom;
    endtask

    task automatic pulse_reset();
        drive('0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", outs_valid); end
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs); end
        total++; if (index !== '0) begin bad++; $display("FAIL reset_index got=%0d want=0", index); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        dat[2] = 32'hDEAD_BEEF;
        drive(3'b100, 1'b1);
        tick();
        total++; if (outs_valid !== 1'b1 || outs !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prefill got=%b/%h want=1/deadbeef", outs_valid, outs); end
        drive(3'b000, 1'b0);
        rst = 1'b1;
        #1;
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", outs_valid); end
        total++; if (outs !== '0) begin bad++; $display("FAIL async_outs got=%h want=0", outs); end
        total++; if (index !== '0) begin bad++; $display("FAIL async_index got=%0d want=0", index); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        randomize_data();
        drive(3'b111, 1'b1);
        total++; if (ins_ready !== 3'b001) begin bad++; $display("FAIL post_reset_ready got=%b want=001", ins_ready); end
        tick();
        total++; if (index !== 2'd0 || outs !== dat[0]) begin bad++; $display("FAIL post_reset_grant got=%0d/%h want=0/%h", index, outs, dat[0]); end
    endtask

    task automatic test_single();
        randomize_data();
        dat[1] = 32'h0000_00A5;
        drive(3'b010, 1'b1);
        total++; if (ins_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b want=010", ins_ready); end
        tick();
        total++; if (outs_valid !== 1'b1 || outs !== 32'hA5 || index !== 2'd1) begin bad++; $display("FAIL single_out got=%b/%h/%0d want=1/a5/1", outs_valid, outs, index); end
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            randomize_data();
            drive(3'b111, 1'b1);
            want = N'(1 << (c % N));
            total++; if (ins_ready !== want || ins_ready !== exp_ready()) begin bad++; $display("FAIL rot_ready cyc=%0d got=%b want=%b", c, ins_ready, want); end
            tick();
            total++; if (outs_valid !== 1'b1 || index !== IW'(c % N) || outs !== m_data) begin bad++; $display("FAIL rot_out cyc=%0d got=%b/%0d/%h want=1/%0d/%h", c, outs_valid, index, outs, c % N, m_data); end
        end
    endtask

    task automatic test_skip();
        pulse_reset();
        randomize_data();
        drive(3'b001, 1'b1);
        tick();
        drive(3'b101, 1'b1);
        total++; if (ins_ready !== 3'b100) begin bad++; $display("FAIL skip_ready1 got=%b want=100", ins_ready); end
        tick();
        total++; if (index !== 2'd2 || outs !== dat[2]) begin bad++; $display("FAIL skip_idx1 got=%0d want=2", index); end
        drive(3'b101, 1'b1);
        total++; if (ins_ready !== 3'b001) begin bad++; $display("FAIL skip_ready2 got=%b want=001", ins_ready); end
        tick();
        total++; if (index !== 2'd0 || outs !== dat[0]) begin bad++; $display("FAIL skip_idx2 got=%0d want=0", index); end
    endtask

    task automatic test_backpressure();
        dat[0] = 32'h11;
        drive(3'b001, 1'b1);
        tick();
        total++; if (outs !== 32'h11 || index !== 2'd0) begin bad++; $display("FAIL bp_fill got=%h/%0d want=11/0", outs, index); end
        for (int c = 0; c < 4; c++) begin
            randomize_data();
            drive(3'b111, 1'b0);
            total++; if (ins_ready !== 3'b000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=000", c, ins_ready); end
            tick();
            total++; if (outs_valid !== 1'b1 || outs !== 32'h11 || index !== 2'd0) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=1/11/0", c, outs_valid, outs, index); end
        end
        dat[1] = 32'h22;
        drive(3'b010, 1'b1);
        total++; if (ins_ready !== 3'b010) begin bad++; $display("FAIL bp_release_ready got=%b want=010", ins_ready); end
        tick();
        total++; if (outs_valid !== 1'b1 || outs !== 32'h22 || index !== 2'd1) begin bad++; $display("FAIL bp_release got=%b/%h/%0d want=1/22/1", outs_valid, outs, index); end
    endtask

    task automatic test_drain();
        drive(3'b000, 1'b1);
        tick();
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", outs_valid); end
        total++; if (outs !== 32'h22 || index !== 2'd1) begin bad++; $display("FAIL drain_hold got=%h/%0d want=22/1", outs, index); end
        drive(3'b000, 1'b1);
        tick();
        randomize_data();
        drive(3'b111, 1'b1);
        total++; if (ins_ready !== 3'b100 || ins_ready !== exp_ready()) begin bad++; $display("FAIL drain_ptr got=%b want=100", ins_ready); end
        tick();
        total++; if (index !== 2'd2 || outs !== dat[2]) begin bad++; $display("FAIL drain_next got=%0d want=2", index); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic         r;
        for (int c = 0; c < 300; c++) begin
            randomize_data();
            v = N'($urandom_range(0, 7));
            r = ($urandom_range(0, 3) != 0);
            drive(v, r);
            total++; if (ins_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, ins_ready, exp_ready()); end
            tick();
            total++; if (outs_valid !== m_full) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, outs_valid, m_full); end
            if (m_full) begin
                total++; if (outs !== m_data || index !== IW'(m_idx)) begin bad++; $display("FAIL rnd_out cyc=%0d got=%h/%0d want=%h/%0d", c, outs, index, m_data, m_idx); end
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        ins_valid  = '0;
        outs_ready = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_skip();
        test_backpressure();
        test_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
